// File: rtl/cic_decim.sv
// cic_decim -- cascaded integrator-comb decimator.
//
// N integrators run at the input sample rate. An internal counter marks every
// R-th input strobe as a decimation event. Each event starts a time-shared comb
// pass: one subtractor is stepped through the N comb stages, one stage per clock.
// The comb result is normalised back to bw bits by a rate-dependent right shift.
//
// Optional build macro: CIC_DECIM_ROUND_EN
//   defined   : round-half-up before the shift, then saturate to bw bits
//   undefined : plain truncation (floor), no saturation
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high; clears all state
//   enable      low = synchronous clear of all state and outputs
//   rate[7:0]   decimation factor R; 0 is treated as 1 and >2^log2_of_max_rate
//               is treated as 2^log2_of_max_rate
//   strobe_in   one-cycle pulse per valid input sample
//   signal_in   input sample, two's complement, valid while strobe_in is high
//   strobe_out  one-cycle pulse per output sample
//   signal_out  output sample, held between strobe_out pulses
//   overrun     one-cycle pulse when a decimation event is dropped
//   fsm_state   current comb-sequencer state (debug observation)
//
// Handshake: strobe_in and strobe_out are single-cycle valid pulses with no
// backpressure. A sample is taken on every clock edge where strobe_in is high,
// and the output is valid for exactly the cycle in which strobe_out is high.
// A decimation event that finds the comb sequencer busy is discarded and
// reported on overrun. The integrators and the counter still advance.
module cic_decim #(
    parameter int bw               = 16,
    parameter int N                = 4,
    parameter int log2_of_max_rate = 7,
    parameter int maxbitgain       = N * log2_of_max_rate
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [7:0]    rate,
    input  logic          strobe_in,
    input  logic [bw-1:0] signal_in,
    output logic          strobe_out,
    output logic [bw-1:0] signal_out,
    output logic          overrun,
    output logic [1:0]    fsm_state
);

    localparam int W  = bw + maxbitgain;
    localparam int RW = log2_of_max_rate + 1;
    localparam int CW = (log2_of_max_rate > 0) ? log2_of_max_rate : 1;
    localparam int LW = $clog2(log2_of_max_rate + 1);
    localparam int SW = $clog2(maxbitgain + 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [7:0]    RATE_CAP = 8'(1 << log2_of_max_rate);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_COMB    = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]           state;
    logic [KW-1:0]        k;
    logic [CW-1:0]        count;
    logic signed [W-1:0]  integ [N];
    logic signed [W-1:0]  delay [N];
    logic signed [W-1:0]  x;

    logic [RW-1:0]        r_eff;
    logic [LW-1:0]        clog_r;
    logic [SW-1:0]        shift;
    logic                 count_last;
    logic                 dec_event;
    logic signed [W:0]    x_ext;
    logic signed [W:0]    x_sh;
    logic [bw-1:0]        norm;

    assign fsm_state = state;

    // Clamp the requested rate into the legal range 1..2^log2_of_max_rate.
    always_comb begin
        if (rate == 8'd0) begin
            r_eff = RW'(1);
        end else if (rate > RATE_CAP) begin
            r_eff = RW'(RATE_CAP);
        end else begin
            r_eff = RW'(rate);
        end
    end

    // ceil(log2(R)): the number of powers of two that are strictly below R.
    always_comb begin
        clog_r = '0;
        for (int i = 0; i < log2_of_max_rate; i++) begin
            if ((RW'(1) << i) < r_eff) begin
                clog_r = LW'(i + 1);
            end
        end
    end

    assign shift = SW'(int'(clog_r) * N);

    // Use >= instead of == so that a rate lowered while running still wraps at once
    // and does not walk the counter through its whole range.
    assign count_last = (count >= CW'(r_eff - RW'(1)));
    assign dec_event  = strobe_in && count_last;

    // Normalisation of the comb result down to bw bits.
`ifdef CIC_DECIM_ROUND_EN
    localparam logic signed [W:0] SAT_MAX = {{(W - bw + 2){1'b0}}, {(bw - 1){1'b1}}};
    localparam logic signed [W:0] SAT_MIN = ~SAT_MAX;
    logic signed [W:0] half;

    always_comb begin
        x_ext = {x[W-1], x};
        half  = (shift == '0) ? '0 : ((W + 1)'(1) << (shift - SW'(1)));
        x_sh  = (x_ext + half) >>> shift;
        if (x_sh > SAT_MAX) begin
            norm = SAT_MAX[bw-1:0];
        end else if (x_sh < SAT_MIN) begin
            norm = SAT_MIN[bw-1:0];
        end else begin
            norm = x_sh[bw-1:0];
        end
    end
`else
    always_comb begin
        x_ext = {x[W-1], x};
        x_sh  = x_ext >>> shift;
        norm  = x_sh[bw-1:0];
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= '0;
            count      <= '0;
            x          <= '0;
            strobe_out <= 1'b0;
            signal_out <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                integ[i] <= '0;
                delay[i] <= '0;
            end
        end else if (!enable) begin
            state      <= S_IDLE;
            k          <= '0;
            count      <= '0;
            x          <= '0;
            strobe_out <= 1'b0;
            signal_out <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                integ[i] <= '0;
                delay[i] <= '0;
            end
        end else begin
            strobe_out <= 1'b0;
            overrun    <= dec_event && (state != S_IDLE);

            // Every integrator adds the registered value of the stage before it.
            // This gives a pipelined chain, so the final stage lags the input by
            // N-1 samples.
            if (strobe_in) begin
                integ[0] <= integ[0] + {{(W - bw){signal_in[bw-1]}}, signal_in};
                for (int i = 1; i < N; i++) begin
                    integ[i] <= integ[i] + integ[i-1];
                end
                count <= count_last ? '0 : count + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (dec_event) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // The event edge has already updated the last integrator.
                    x     <= integ[N-1];
                    k     <= '0;
                    state <= S_COMB;
                end
                S_COMB: begin
                    // One shared subtractor steps through the comb stages in turn.
                    x        <= x - delay[k];
                    delay[k] <= x;
                    if (k == K_LAST) begin
                        state <= S_OUT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_OUT: begin
                    signal_out <= norm;
                    strobe_out <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_decim.sv
// Directed testbench for cic_decim with the default parameters (bw=16, N=4,
// max rate 128). The expected values are worked out by hand from the impulse
// response z^-3 * (1 + z^-1 + ... + z^-(R-1))^4. The z^-3 is the pipelined
// integrator chain.
module tb_cic_decim;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  rate;
    logic        strobe_in;
    logic [15:0] signal_in;
    logic        strobe_out;
    logic [15:0] signal_out;
    logic        overrun;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ovr = 0;
    int last_ev;

    logic [15:0] exp_q[$];
    int          out_v_q[$];
    int          out_t_q[$];
    int          ev_q[$];

    cic_decim dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .rate       (rate),
        .strobe_in  (strobe_in),
        .signal_in  (signal_in),
        .strobe_out (strobe_out),
        .signal_out (signal_out),
        .overrun    (overrun),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- output monitor (scoreboard capture) ----------------
    always @(negedge clock) begin
        if (strobe_out) begin
            out_v_q.push_back(int'($signed(signal_out)));
            out_t_q.push_back(cyc);
        end
        if (overrun) n_ovr++;
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send(input int v, input int gap);
        signal_in = 16'(v);
        strobe_in = 1'b1;
        tick();
        last_ev   = cyc;
        strobe_in = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic flush_clear();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        out_v_q.delete();
        out_t_q.delete();
        ev_q.delete();
        exp_q.delete();
        n_ovr = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_count"}, out_v_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_v_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), out_v_q[i], int'($signed(exp_q[i])));
        end
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        rate      = 8'd1;
        strobe_in = 1'b0;
        signal_in = '0;
        repeat (3) tick();

        check("rst_signal_out", int'(signal_out), 0);
        check("rst_strobe_out", int'(strobe_out), 0);
        check("rst_overrun",    int'(overrun), 0);
        check("rst_state",      int'(fsm_state), 0);

        reset  = 1'b0;
        enable = 1'b1;
        tick();

        // R=1 passes the input through, delayed by 3 samples.
        send(500, 8); send(0, 8); send(0, 8); send(0, 8);
        check("pre_rst_value", int'($signed(signal_out)), 500);

        // Assert reset asynchronously while the comb pass is running.
        send(-3, 3);
        check("mid_comb_state", int'(fsm_state), 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_signal_out", int'(signal_out), 0);
        check("async_rst_strobe_out", int'(strobe_out), 0);
        check("async_rst_state",      int'(fsm_state), 0);
        tick();
        reset = 1'b0;
        tick();
        flush_clear();

        // Drop enable for one cycle mid-COMB.
        send(500, 3);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (10) tick();
        check("en_drop_no_strobe", out_v_q.size(), 0);
        check("en_drop_signal_out", int'(signal_out), 0);
        check("en_drop_state", int'(fsm_state), 0);
        // If the integrators had kept the 500, it would appear in this output stream.
        send(0, 8); send(0, 8); send(0, 8); send(321, 8);
        send(0, 8); send(0, 8); send(0, 8);
        exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
        exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
        exp_q.push_back(16'd321);
        check_outputs("en_drop_after");

        // DC 1000 at R=4. Cumulative taps 1, 66, 221, 256 of 256.
        rate = 8'd4;
        flush_clear();
        for (int i = 0; i < 20; i++) begin
            send(1000, 8);
            if (i % 4 == 3) ev_q.push_back(last_ev);
        end
        repeat (8) tick();
`ifdef CIC_DECIM_ROUND_EN
        exp_q.push_back(16'd4);   exp_q.push_back(16'd258);
`else
        exp_q.push_back(16'd3);   exp_q.push_back(16'd257);
`endif
        exp_q.push_back(16'd863); exp_q.push_back(16'd1000); exp_q.push_back(16'd1000);
        if (out_t_q.size() >= 5 && ev_q.size() >= 5) begin
            check("dc_r4_latency_first", out_t_q[0] - ev_q[0], 6);
            check("dc_r4_latency_last",  out_t_q[4] - ev_q[4], 6);
            check("dc_r4_period",        out_t_q[1] - out_t_q[0], 32);
        end else begin
            check("dc_r4_timing_outputs", out_t_q.size(), 5);
        end
        check_outputs("dc_r4");

        // R=1 impulse, lossless spacing of 7 clocks.
        rate = 8'd1;
        flush_clear();
        send(0, 7); send(0, 7); send(100, 7); send(0, 7);
        send(0, 7); send(0, 7); send(0, 7);
        repeat (4) tick();
        for (int i = 0; i < 7; i++) exp_q.push_back((i == 5) ? 16'd100 : 16'd0);
        check("impulse_overrun", n_ovr, 0);
        check_outputs("impulse_r1");

        // rate=0 behaves as R=1.
        rate = 8'd0;
        flush_clear();
        send(7, 7);
        ev_q.push_back(last_ev);
        send(0, 7); send(0, 7); send(0, 7); send(0, 7);
        repeat (4) tick();
        if (out_t_q.size() > 0) check("rate0_latency", out_t_q[0] - ev_q[0], 6);
        else check("rate0_any_output", out_t_q.size(), 5);
        exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
        exp_q.push_back(16'd7); exp_q.push_back(16'd0);
        check_outputs("rate0");

        // Full-scale negative DC at R=128: -2^15 * 2^28 exactly fills 44 bits.
        rate = 8'd128;
        flush_clear();
        for (int i = 0; i < 6 * 128; i++) send(-32768, 1);
        repeat (10) tick();
        check("fs_neg_count", out_v_q.size(), 6);
        if (out_v_q.size() >= 6) begin
            check("fs_neg_out5", out_v_q[4], -32768);
            check("fs_neg_out6", out_v_q[5], -32768);
        end

        // Full-scale positive DC at R=128.
        flush_clear();
        for (int i = 0; i < 6 * 128; i++) send(32767, 1);
        repeat (10) tick();
        check("fs_pos_count", out_v_q.size(), 6);
        if (out_v_q.size() >= 6) begin
            check("fs_pos_out5", out_v_q[4], 32767);
            check("fs_pos_out6", out_v_q[5], 32767);
        end

        // rate=200 is clamped to 128: one output per 128 strobes, unity DC gain.
        rate = 8'd200;
        flush_clear();
        for (int i = 0; i < 5 * 128; i++) begin
            send(256, 1);
            if (i % 128 == 127) ev_q.push_back(last_ev);
        end
        repeat (10) tick();
        check("clamp_count", out_v_q.size(), 5);
        if (out_v_q.size() >= 5 && ev_q.size() >= 5) begin
            check("clamp_latency", out_t_q[0] - ev_q[0], 6);
            check("clamp_period",  out_t_q[1] - out_t_q[0], 128);
            check("clamp_out4",    out_v_q[3], 256);
            check("clamp_out5",    out_v_q[4], 256);
        end

        // Overrun: R=1 with strobes 2 clocks apart. Only every 4th event finds IDLE.
        rate = 8'd1;
        flush_clear();
        for (int i = 0; i < 12; i++) send(0, 2);
        repeat (10) tick();
        check("overrun_pulses", n_ovr, 9);
        check("overrun_outputs", out_v_q.size(), 3);
        check("overrun_final_state", int'(fsm_state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_decim.md
# cic_decim

Cascaded integrator-comb decimator: N integrators at the input sample rate, a decimation counter that generates the output strobe internally, and a time-shared N-stage comb pass per output sample. Output is normalized to bw bits by a rate-dependent shift. Sits in the receive chain between the digital down-converter mixer and the halfband decimator, mirroring the transmit-side CIC interpolator.

## Interface
- bw, 16: input/output sample width, two's complement
- N, 4: number of integrator and comb stages
- log2_of_max_rate, 7: log2 of the maximum decimation (128)
- maxbitgain, N*log2_of_max_rate: internal bit growth; internal width W = bw+maxbitgain (44 by default)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  low = synchronous clear of all state and outputs
- rate  in  8  decimation factor R; legal 1..128
- strobe_in  in  1  one-cycle pulse per valid input sample
- signal_in  in  bw  input sample, valid when strobe_in high
- strobe_out  out  1  one-cycle pulse per output sample
- signal_out  out  bw  output sample, held between strobe_out pulses
- overrun  out  1  one-cycle pulse when a decimation event is dropped

## Operation
- Reset value of every output and register: 0. FSM in IDLE.
- enable low: same clear as reset, synchronously; sticks while low.
- rate clamping: rate==0 is treated as R=1; rate>128 as R=128. rate may change only while enable is low; a change while enabled gives an undefined next output, no lock-up.
- Integrators: on strobe_in, integ[0] += sign-extended signal_in; integ[i] += integ[i-1] (registered values). Modulo-2^W wrap, no saturation.
- Decimation counter: 0..R-1, advances on strobe_in, wraps to 0. strobe_in with count==R-1 is a decimation event.
- FSM, states IDLE, CAPTURE, COMB, OUT:
  - IDLE -> CAPTURE on a decimation event.
  - CAPTURE (1 cycle): snapshot integ[N-1] (already updated by the event).
  - COMB (N cycles, stage index k=0..N-1): shared subtractor; y = x - delay[k]; delay[k] <= x; x <= y.
  - OUT (1 cycle): register normalized x into signal_out, pulse strobe_out, -> IDLE.
- Decimation event while FSM is not IDLE: event dropped, overrun pulses, integrators and counter still advance.
- Normalization: shift = N*ceil(log2 R) (R=1 -> 0, R=128 -> 28); signal_out = x[bw+shift-1:shift]. Non-power-of-2 R is under-scaled by design.

## Timing
- Decimation event sampled at edge t: CAPTURE at t+1, COMB at t+2..t+N+1, signal_out/strobe_out updated at edge t+N+2. strobe_out high for exactly one cycle.
- Minimum strobe_in spacing for loss-free operation at R=1: N+3 clocks (7 at default). For R>1, events must be at least N+3 clocks apart.
- The first N outputs after reset or enable are comb warm-up transients.
- overrun is asserted in the cycle after the dropped event's edge.

## Configuration
- CIC_DECIM_ROUND_EN defined: before the shift, add 2^(shift-1) (none when shift=0), then saturate to [-2^(bw-1), 2^(bw-1)-1]. This is round-half-up.
- Not defined: plain truncation (floor). No saturation. Full-scale inputs cannot overflow at power-of-2 R.

## Test plan
- Reset/enable: assert reset mid-COMB. All outputs are 0 immediately and the FSM is in IDLE. Drop enable for 1 cycle mid-COMB. No strobe_out follows and all state is 0.
- DC at R=4: signal_in=1000, strobe_in every 8 clocks. strobe_out every 32 clocks, N+2 clocks after every 4th input strobe. signal_out=1000 from the 5th output onward.
- R=1 impulse: strobe_in every 7 clocks, one sample of 100, otherwise 0. Exactly one output equals 100, and the rest are 0.
- Full scale at R=128: signal_in=-32768 constant. After warm-up, signal_out=-32768 with no wrap. With CIC_DECIM_ROUND_EN, +32767 input yields 32767.
- Overrun: R=1, strobe_in every 2 clocks. overrun pulses for every event arriving in a non-IDLE state. strobe_out count equals the number of accepted events.
- Rate clamp: rate=0 behaves identically to rate=1. rate=200 behaves identically to rate=128, with a strobe_out period of 128 input strobes.
